// File: rtl/i2c_pkg.sv
// Shared I2C definitions: trigger sequencer states and byte/ACK constants.
package i2c_pkg;

  localparam int   I2C_BYTE_BITS = 8;
  localparam logic I2C_ACK       = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_SHIFT,
    ST_ACK,
    ST_DONE
  } i2c_trig_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw scl/sda into the clk domain and flags scl rise, START and STOP.
// Port `reset` is active-low; everything resets to the idle-bus level so no false START.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   r_scl_rise;
  logic                   r_start;
  logic                   r_stop;
  logic                   r_sda_out;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Detectors are registered so every bus event lands SYNC_STAGES+1 cycles after the pin,
  // with sda_s aligned to the same cycle as scl_rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      r_scl_rise <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_sda_out  <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
      r_scl_rise <= w_scl & ~r_scl_prev;
      r_start    <= r_scl_prev & w_scl & r_sda_prev & ~w_sda;
      r_stop     <= r_scl_prev & w_scl & ~r_sda_prev & w_sda;
      r_sda_out  <= w_sda;
    end
  end

  assign scl_rise  = r_scl_rise;
  assign start_det = r_start;
  assign stop_det  = r_stop;
  assign sda_s     = r_sda_out;

endmodule

// File: rtl/i2c_trigger_ctrl.sv
// Programmable I2C trigger: matches the byte stream after each START against a loaded
// pattern and pulses `trigger` when every pattern byte arrives ACKed. `reset` is active-low.
module i2c_trigger_ctrl
  import i2c_pkg::*;
#(
  parameter int NUM_BYTES   = 4,
  parameter int SYNC_STAGES = 2,
  localparam int LW = $clog2(NUM_BYTES + 1),
  localparam int AW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl,
  input  logic          sda,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [7:0]    cfg_data,
  input  logic [LW-1:0] cfg_len,
  input  logic          arm,
  input  logic          disarm,
  output logic          armed,
  output logic          byte_valid,
  output logic [7:0]    byte_out,
  output logic          ack_out,
  output logic          trigger,
  output logic [LW-1:0] match_idx
);

  localparam logic [LW-1:0] MAX_LEN  = LW'(NUM_BYTES);
  localparam logic [3:0]    LAST_BIT = 4'(I2C_BYTE_BITS - 1);

  logic w_scl_rise;
  logic w_start;
  logic w_stop;
  logic w_sda;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (w_scl_rise),
    .start_det(w_start),
    .stop_det (w_stop),
    .sda_s    (w_sda)
  );

  i2c_trig_state_t r_state;
  i2c_trig_state_t w_state_nxt;
  logic [3:0]      r_bitcnt;
  logic [3:0]      w_bitcnt_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic [7:0]      r_pattern [NUM_BYTES];
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   w_len_nxt;
  logic [LW-1:0]   r_match_idx;
  logic [LW-1:0]   w_match_nxt;
  logic [LW-1:0]   w_idx_inc;
  logic            r_armed;
  logic            w_armed_nxt;
  logic            r_byte_valid;
  logic            w_byte_valid_nxt;
  logic [7:0]      r_byte_out;
  logic [7:0]      w_byte_out_nxt;
  logic            r_ack_out;
  logic            w_ack_nxt;
  logic            r_trigger;
  logic            w_trigger_nxt;
  logic [7:0]      w_pat_cur;
  logic            w_len_ok;
  logic            w_byte_match;

  assign w_pat_cur    = r_pattern[r_match_idx[AW-1:0]];
  assign w_idx_inc    = r_match_idx + LW'(1);
  assign w_len_ok     = (cfg_len != '0) && (cfg_len <= MAX_LEN);
  assign w_byte_match = (r_shift == w_pat_cur) && (w_sda == I2C_ACK);

  // Pattern file is writable only while disarmed and keeps its contents across arms.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BYTES; i++) r_pattern[i] <= '0;
    end else if (cfg_we && (r_state == ST_IDLE) && (int'(cfg_addr) < NUM_BYTES)) begin
      r_pattern[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_len        <= '0;
      r_match_idx  <= '0;
      r_armed      <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte_out   <= '0;
      r_ack_out    <= 1'b1;
      r_trigger    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_shift      <= w_shift_nxt;
      r_len        <= w_len_nxt;
      r_match_idx  <= w_match_nxt;
      r_armed      <= w_armed_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_byte_out   <= w_byte_out_nxt;
      r_ack_out    <= w_ack_nxt;
      r_trigger    <= w_trigger_nxt;
    end
  end

  // Within a transfer, START beats STOP beats scl rise; disarm overrides everything.
  always_comb begin
    w_state_nxt      = r_state;
    w_bitcnt_nxt     = r_bitcnt;
    w_shift_nxt      = r_shift;
    w_len_nxt        = r_len;
    w_match_nxt      = r_match_idx;
    w_armed_nxt      = r_armed;
    w_byte_valid_nxt = 1'b0;
    w_byte_out_nxt   = r_byte_out;
    w_ack_nxt        = r_ack_out;
    w_trigger_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (arm && w_len_ok) begin
          w_len_nxt   = cfg_len;
          w_match_nxt = '0;
          w_armed_nxt = 1'b1;
          w_state_nxt = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (w_start) begin
          w_bitcnt_nxt = '0;
          w_match_nxt  = '0;
          w_state_nxt  = ST_SHIFT;
        end
      end
      ST_SHIFT, ST_ACK: begin
        if (w_start) begin
          w_bitcnt_nxt = '0;
          w_match_nxt  = '0;
          w_state_nxt  = ST_SHIFT;
        end else if (w_stop) begin
          w_match_nxt = '0;
          w_state_nxt = ST_WAIT_START;
        end else if (w_scl_rise) begin
          if (r_state == ST_SHIFT) begin
            w_shift_nxt  = {r_shift[6:0], w_sda};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_bitcnt == LAST_BIT) w_state_nxt = ST_ACK;
          end else begin
            w_byte_valid_nxt = 1'b1;
            w_byte_out_nxt   = r_shift;
            w_ack_nxt        = w_sda;
            w_bitcnt_nxt     = '0;
            if (!w_byte_match) begin
              w_match_nxt = '0;
              w_state_nxt = ST_WAIT_START;
            end else if (w_idx_inc == r_len) begin
              w_match_nxt   = w_idx_inc;
              w_trigger_nxt = 1'b1;
              w_armed_nxt   = 1'b0;
              w_state_nxt   = ST_DONE;
            end else begin
              w_match_nxt = w_idx_inc;
              w_state_nxt = ST_SHIFT;
            end
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (disarm) begin
      w_state_nxt   = ST_IDLE;
      w_armed_nxt   = 1'b0;
      w_trigger_nxt = 1'b0;
    end
  end

  assign armed      = r_armed;
  assign byte_valid = r_byte_valid;
  assign byte_out   = r_byte_out;
  assign ack_out    = r_ack_out;
  assign trigger    = r_trigger;
  assign match_idx  = r_match_idx;

endmodule

// File: tb/tb_i2c_trigger_ctrl.sv
// Scoreboard bench for i2c_trigger_ctrl: bus tasks feed a transfer-level pattern model
// that queues expected byte reports; a monitor pops them whenever byte_valid pulses.
module tb_i2c_trigger_ctrl;

  localparam int NB = 4;
  localparam int SS = 2;
  localparam int LW = $clog2(NB + 1);
  localparam int AW = $clog2(NB);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          scl = 1'b1;
  logic          sda = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [7:0]    cfg_data = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          arm = 1'b0;
  logic          disarm = 1'b0;
  logic          armed;
  logic          byte_valid;
  logic [7:0]    byte_out;
  logic          ack_out;
  logic          trigger;
  logic [LW-1:0] match_idx;

  i2c_trigger_ctrl #(
    .NUM_BYTES  (NB),
    .SYNC_STAGES(SS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_len   (cfg_len),
    .arm       (arm),
    .disarm    (disarm),
    .armed     (armed),
    .byte_valid(byte_valid),
    .byte_out  (byte_out),
    .ack_out   (ack_out),
    .trigger   (trigger),
    .match_idx (match_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    b;
    logic          ack;
    logic          trig;
    logic [LW-1:0] idx;
    logic          armed;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  logic [7:0] mPat [NB];
  int         mLen = 0;
  int         mIdx = 0;
  bit         mArmed = 0;
  bit         mTracking = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every byte_valid pulse must match the oldest predicted byte report.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      if (byte_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_byte_valid actual byte=%02h ack=%0b expected none t=%0t",
                   byte_out, ack_out, $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("byte_out", 32'(byte_out), 32'(e.b));
          checkOutput("ack_out", 32'(ack_out), 32'(e.ack));
          checkOutput("trigger_with_byte", 32'(trigger), 32'(e.trig));
          checkOutput("match_idx_after_byte", 32'(match_idx), 32'(e.idx));
          checkOutput("armed_after_byte", 32'(armed), 32'(e.armed));
        end
      end else if (trigger) begin
        checks++;
        failures++;
        $display("[TB] FAIL trigger_without_byte actual=1 expected=0 t=%0t", $time);
      end
    end
  end

  // Reference model: matching is tracked per transfer (from a START) in plain terms.
  task automatic modelStart();
    if (mArmed) begin
      mIdx = 0;
      mTracking = 1;
    end
  endtask

  task automatic modelStop();
    mTracking = 0;
    if (mArmed) mIdx = 0;
  endtask

  task automatic modelByte(input logic [7:0] b, input logic ack);
    exp_t e;
    if (mArmed && mTracking) begin
      e.b = b;
      e.ack = ack;
      e.trig = 1'b0;
      if (b == mPat[mIdx] && ack == 1'b0) begin
        mIdx++;
        if (mIdx == mLen) begin
          e.trig = 1'b1;
          mArmed = 0;
          mTracking = 0;
        end
      end else begin
        mIdx = 0;
        mTracking = 0;
      end
      e.idx = LW'(mIdx);
      e.armed = mArmed;
      expQ.push_back(e);
    end
  endtask

  task automatic phaseWait();
    repeat (4) @(negedge clk);
  endtask

  task automatic busBit(input logic b);
    sda = b;
    phaseWait();
    scl = 1'b1;
    phaseWait();
    scl = 1'b0;
    phaseWait();
  endtask

  task automatic busStart();
    modelStart();
    sda = 1'b1;
    phaseWait();
    scl = 1'b1;
    phaseWait();
    sda = 1'b0;
    phaseWait();
    scl = 1'b0;
    phaseWait();
  endtask

  task automatic busStop();
    sda = 1'b0;
    phaseWait();
    scl = 1'b1;
    phaseWait();
    sda = 1'b1;
    phaseWait();
    modelStop();
  endtask

  task automatic busByte(input logic [7:0] b, input logic ack);
    modelByte(b, ack);
    for (int i = 7; i >= 0; i--) busBit(b[i]);
    busBit(ack);
  endtask

  task automatic busPartial(input int n);
    for (int i = 0; i < n; i++) busBit(1'($urandom_range(0, 1)));
  endtask

  task automatic writePat(input int addr, input logic [7:0] data);
    cfg_addr = AW'(addr);
    cfg_data = data;
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    if (!mArmed) mPat[addr] = data;
  endtask

  task automatic doArm(input int len);
    cfg_len = LW'(len);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    if (!mArmed && len >= 1 && len <= NB) begin
      mArmed = 1;
      mLen = len;
      mIdx = 0;
      mTracking = 0;
    end
  endtask

  task automatic doDisarm();
    disarm = 1'b1;
    @(negedge clk);
    disarm = 1'b0;
    mArmed = 0;
    mTracking = 0;
  endtask

  // One randomized transfer; bytes lean towards the next pattern byte so triggers happen.
  task automatic applyStimulus();
    int nBytes;
    logic [7:0] b;
    logic ack;
    if (!mArmed) begin
      for (int a = 0; a < NB; a++) writePat(a, 8'($urandom));
      doArm($urandom_range(0, NB));
    end
    busStart();
    nBytes = $urandom_range(1, 5);
    for (int k = 0; k < nBytes; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        busPartial($urandom_range(1, 7));
        busStart();
      end
      if (mArmed && mTracking && $urandom_range(0, 3) != 0) b = mPat[mIdx];
      else b = 8'($urandom);
      ack = ($urandom_range(0, 7) == 0);
      busByte(b, ack);
    end
    busStop();
    repeat (4) @(negedge clk);
    if (mArmed && $urandom_range(0, 7) == 0) doDisarm();
  endtask

  initial begin
    for (int i = 0; i < NB; i++) mPat[i] = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_armed", 32'(armed), 32'd0);
    checkOutput("reset_byte_valid", 32'(byte_valid), 32'd0);
    checkOutput("reset_trigger", 32'(trigger), 32'd0);
    checkOutput("reset_byte_out", 32'(byte_out), 32'd0);
    checkOutput("reset_ack_out", 32'(ack_out), 32'd1);
    checkOutput("reset_match_idx", 32'(match_idx), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Two-byte match with a trigger on the second ACK.
    writePat(0, 8'hA0);
    writePat(1, 8'h10);
    doArm(2);
    checkOutput("armed_after_arm", 32'(armed), 32'd1);
    busStart();
    busByte(8'hA0, 1'b0);
    busByte(8'h10, 1'b0);
    busStop();
    checkOutput("armed_after_trigger", 32'(armed), 32'd0);
    checkOutput("match_idx_after_trigger", 32'(match_idx), 32'd2);

    // Wrong second byte: stays armed, next good transfer triggers.
    doArm(2);
    busStart();
    busByte(8'hA0, 1'b0);
    busByte(8'h11, 1'b0);
    busStop();
    checkOutput("armed_after_mismatch", 32'(armed), 32'd1);
    checkOutput("match_idx_after_mismatch", 32'(match_idx), 32'd0);
    busStart();
    busByte(8'hA0, 1'b0);
    busByte(8'h10, 1'b0);
    busStop();
    checkOutput("armed_after_retry", 32'(armed), 32'd0);

    // Right byte but NACKed.
    writePat(0, 8'h42);
    doArm(1);
    busStart();
    busByte(8'h42, 1'b1);
    busStop();
    checkOutput("nack_ack_out", 32'(ack_out), 32'd1);
    checkOutput("nack_still_armed", 32'(armed), 32'd1);
    doDisarm();

    // Repeated START after a partial byte.
    writePat(0, 8'hA0);
    doArm(2);
    busStart();
    busByte(8'hA0, 1'b0);
    busPartial(3);
    busStart();
    busByte(8'hA0, 1'b0);
    busByte(8'h10, 1'b0);
    busStop();
    checkOutput("armed_after_restart", 32'(armed), 32'd0);

    // Rejected arms.
    doArm(0);
    checkOutput("arm_len0", 32'(armed), 32'd0);
    doArm(NB + 1);
    checkOutput("arm_len_too_big", 32'(armed), 32'd0);
    cfg_len = LW'(2);
    arm = 1'b1;
    disarm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    disarm = 1'b0;
    checkOutput("arm_disarm_same_cycle", 32'(armed), 32'd0);

    // Pattern write while armed is dropped; original pattern still triggers.
    doArm(2);
    writePat(0, 8'hFF);
    cfg_len = LW'(1);
    busStart();
    busByte(8'hA0, 1'b0);
    busByte(8'h10, 1'b0);
    busStop();
    checkOutput("cfg_we_ignored_armed", 32'(armed), 32'd0);

    // Reset in the middle of a byte, released with the bus idle.
    doArm(1);
    busStart();
    busPartial(4);
    reset = 1'b0;
    @(negedge clk);
    scl = 1'b1;
    sda = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    mArmed = 0;
    mTracking = 0;
    for (int i = 0; i < NB; i++) mPat[i] = 8'h00;
    repeat (10) @(negedge clk);
    checkOutput("midreset_armed", 32'(armed), 32'd0);
    checkOutput("midreset_byte_out", 32'(byte_out), 32'd0);
    checkOutput("midreset_ack_out", 32'(ack_out), 32'd1);
    checkOutput("midreset_match_idx", 32'(match_idx), 32'd0);
    doArm(1);
    scl = 1'b0;
    phaseWait();
    busByte(8'h00, 1'b0);
    busStop();
    checkOutput("no_start_no_match", 32'(armed), 32'd1);
    busStart();
    busByte(8'h00, 1'b0);
    busStop();
    checkOutput("reset_pattern_zero_trigger", 32'(armed), 32'd0);

    for (int n = 0; n < 25; n++) applyStimulus();

    repeat (20) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
